// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - width helpers and priority-order constants shared by the priority encoders
package pe_pkg;

  localparam int PRIO_LSB = 0;
  localparam int PRIO_MSB = 1;

  function automatic int clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Smallest power of 4 that is >= v (minimum 4); the encoder tree pads to this size.
  function automatic int pow4_ceil(input int v);
    int p;
    p = 4;
    while (p < v) p = p * 4;
    return p;
  endfunction

endpackage

// File: rtl/pe_comb.sv
// rtl/pe_comb.sv - combinational recursive 4-way priority encoder, LSB- or MSB-first
module pe_comb
  import pe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic [WIDTH-1:0]        req,
  output logic [clog2(WIDTH)-1:0] bin,
  output logic                    vld
);

  localparam int L2W = clog2(WIDTH);
  localparam int PW  = pow4_ceil(WIDTH);
  localparam int L2P = clog2(PW);

  logic [PW-1:0]  padded;
  logic [L2P-1:0] pbin;

  assign padded = PW'(req);

  if (PW == 4) begin : g_leaf
    always_comb begin
      pbin = '0;
      if (MSB_FIRST == PRIO_MSB) begin
        if (padded[3])      pbin = 2'd3;
        else if (padded[2]) pbin = 2'd2;
        else if (padded[1]) pbin = 2'd1;
        else                pbin = 2'd0;
      end else begin
        if (padded[0])      pbin = 2'd0;
        else if (padded[1]) pbin = 2'd1;
        else if (padded[2]) pbin = 2'd2;
        else if (padded[3]) pbin = 2'd3;
        else                pbin = 2'd0;
      end
    end
    assign vld = |padded;
  end else begin : g_node
    localparam int CW = PW / 4;
    logic [3:0]     cvld;
    logic [L2P-3:0] cbin [4];
    logic [1:0]     sel;

    for (genvar g = 0; g < 4; g++) begin : g_child
      pe_comb #(.WIDTH(CW), .MSB_FIRST(MSB_FIRST)) u_child (
        .req (padded[g*CW +: CW]),
        .bin (cbin[g]),
        .vld (cvld[g])
      );
    end

    // Quadrant choice uses the same priority order as the leaves.
    always_comb begin
      sel = 2'd0;
      if (MSB_FIRST == PRIO_MSB) begin
        if (cvld[3])      sel = 2'd3;
        else if (cvld[2]) sel = 2'd2;
        else if (cvld[1]) sel = 2'd1;
        else              sel = 2'd0;
      end else begin
        if (cvld[0])      sel = 2'd0;
        else if (cvld[1]) sel = 2'd1;
        else if (cvld[2]) sel = 2'd2;
        else if (cvld[3]) sel = 2'd3;
        else              sel = 2'd0;
      end
    end

    assign pbin = {sel, cbin[sel]};
    assign vld  = |cvld;
  end

  if (L2P > L2W) begin : g_trim
    // Padding bits are always zero, so the dropped high index bits are always zero too.
    logic unused_pbin_hi;
    assign unused_pbin_hi = ^pbin[L2P-1:L2W];
  end

  assign bin = pbin[L2W-1:0];

endmodule

// File: rtl/pe_scan.sv
// rtl/pe_scan.sv - handshaked multi-hit priority encoder emitting one set-bit index per cycle
module pe_scan
  import pe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        in_vec,
  input  logic                    in_vld,
  output logic                    in_rdy,
  output logic [clog2(WIDTH)-1:0] out_bin,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    out_last,
  output logic                    busy
);

  localparam int L2W = clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] pend_nxt;
  logic [WIDTH-1:0] clr_mask;
  logic [L2W-1:0]   enc_bin;
  logic             enc_vld;
  logic             hs;
  logic             hs_last;
  logic             load;

  pe_comb #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_enc (
    .req (pend),
    .bin (enc_bin),
    .vld (enc_vld)
  );

  assign busy     = (state == SCAN);
  assign out_vld  = busy & enc_vld;
  assign out_bin  = out_vld ? enc_bin : '0;
  // Exactly one bit left: clearing the lowest set bit empties the vector.
  assign out_last = out_vld & ((pend & (pend - WIDTH'(1))) == '0);

  assign hs       = out_vld & out_rdy;
  assign hs_last  = hs & out_last;
  assign in_rdy   = ((state == IDLE) | hs_last) & ~flush;
  assign load     = in_vld & in_rdy & (|in_vec);
  assign clr_mask = WIDTH'(1) << out_bin;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    if (flush) begin
      state_nxt = IDLE;
      pend_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            pend_nxt  = in_vec;
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          if (hs_last) begin
            if (load) begin
              pend_nxt  = in_vec;
              state_nxt = SCAN;
            end else begin
              pend_nxt  = '0;
              state_nxt = IDLE;
            end
          end else if (hs) begin
            pend_nxt = pend & ~clr_mask;
          end
        end
        default: begin
          state_nxt = IDLE;
          pend_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_pe_scan.sv
// tb/tb_pe_scan.sv - directed vector bench for pe_scan, 16-bit LSB-first and 32-bit MSB-first
module tb_pe_scan;

  typedef struct {
    logic        flush;
    logic [15:0] vec;
    logic        vld;
    logic        rdy;
    logic [7:0]  exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst16, rst32;
  logic        flush16, in_vld16, in_rdy16, out_vld16, out_rdy16, out_last16, busy16;
  logic [15:0] in_vec16;
  logic [3:0]  out_bin16;
  logic        flush32, in_vld32, in_rdy32, out_vld32, out_rdy32, out_last32, busy32;
  logic [31:0] in_vec32;
  logic [4:0]  out_bin32;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl [29];

  always #5 clk = ~clk;

  pe_scan #(.WIDTH(16), .MSB_FIRST(0)) dut16 (
    .clk(clk), .rst(rst16), .flush(flush16), .in_vec(in_vec16), .in_vld(in_vld16),
    .in_rdy(in_rdy16), .out_bin(out_bin16), .out_vld(out_vld16), .out_rdy(out_rdy16),
    .out_last(out_last16), .busy(busy16)
  );

  pe_scan #(.WIDTH(32), .MSB_FIRST(1)) dut32 (
    .clk(clk), .rst(rst32), .flush(flush32), .in_vec(in_vec32), .in_vld(in_vld32),
    .in_rdy(in_rdy32), .out_bin(out_bin32), .out_vld(out_vld32), .out_rdy(out_rdy32),
    .out_last(out_last32), .busy(busy32)
  );

  function automatic vec_t v(input logic fl, input logic [15:0] iv, input logic vl,
                             input logic rd, input logic ov, input logic [3:0] ob,
                             input logic ol, input logic ir, input logic bz);
    vec_t r;
    r.flush = fl;
    r.vec   = iv;
    r.vld   = vl;
    r.rdy   = rd;
    r.exp   = {ov, ob, ol, ir, bz};
    return r;
  endfunction

  function automatic logic [15:0] e32(input logic ov, input logic [4:0] ob, input logic ol,
                                      input logic ir, input logic bz);
    return {7'd0, ov, ob, ol, ir, bz};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {vld,bin,last,in_rdy,busy}=%h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] act16();
    return {8'd0, out_vld16, out_bin16, out_last16, in_rdy16, busy16};
  endfunction

  function automatic logic [15:0] act32();
    return {7'd0, out_vld32, out_bin32, out_last32, in_rdy32, busy32};
  endfunction

  initial begin
    // Each row: inputs for one cycle and the outputs expected in that same cycle.
    tbl[0]  = v(0, 16'h8421, 1, 1, 0,  0, 0, 1, 0);
    tbl[1]  = v(0, 16'h0000, 0, 1, 1,  0, 0, 0, 1);
    tbl[2]  = v(0, 16'h0000, 0, 1, 1,  5, 0, 0, 1);
    tbl[3]  = v(0, 16'h0000, 0, 1, 1, 10, 0, 0, 1);
    tbl[4]  = v(0, 16'h0000, 0, 1, 1, 15, 1, 1, 1);
    tbl[5]  = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);
    tbl[6]  = v(0, 16'h0030, 1, 0, 0,  0, 0, 1, 0);
    tbl[7]  = v(0, 16'h0000, 0, 0, 1,  4, 0, 0, 1);
    tbl[8]  = v(0, 16'h0000, 0, 0, 1,  4, 0, 0, 1);
    tbl[9]  = v(0, 16'h0000, 0, 0, 1,  4, 0, 0, 1);
    tbl[10] = v(0, 16'h0000, 0, 1, 1,  4, 0, 0, 1);
    tbl[11] = v(0, 16'h0000, 0, 1, 1,  5, 1, 1, 1);
    tbl[12] = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);
    tbl[13] = v(0, 16'h0001, 1, 1, 0,  0, 0, 1, 0);
    tbl[14] = v(0, 16'h8000, 1, 1, 1,  0, 1, 1, 1);
    tbl[15] = v(0, 16'h0000, 0, 1, 1, 15, 1, 1, 1);
    tbl[16] = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);
    tbl[17] = v(0, 16'h0000, 1, 1, 0,  0, 0, 1, 0);
    tbl[18] = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);
    tbl[19] = v(0, 16'hFFFF, 1, 1, 0,  0, 0, 1, 0);
    tbl[20] = v(0, 16'h0000, 0, 1, 1,  0, 0, 0, 1);
    tbl[21] = v(0, 16'h0000, 0, 1, 1,  1, 0, 0, 1);
    tbl[22] = v(1, 16'h0100, 1, 0, 1,  2, 0, 0, 1);
    tbl[23] = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);
    tbl[24] = v(0, 16'h0004, 1, 1, 0,  0, 0, 1, 0);
    tbl[25] = v(0, 16'h0000, 0, 1, 1,  2, 1, 1, 1);
    tbl[26] = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);
    tbl[27] = v(1, 16'h0002, 1, 1, 0,  0, 0, 0, 0);
    tbl[28] = v(0, 16'h0000, 0, 1, 0,  0, 0, 1, 0);

    rst16 = 1'b1;  rst32 = 1'b1;
    flush16 = 1'b0; in_vec16 = '0; in_vld16 = 1'b0; out_rdy16 = 1'b0;
    flush32 = 1'b0; in_vec32 = '0; in_vld32 = 1'b0; out_rdy32 = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset16", act16(), 16'h0002);
    chk("reset32", act32(), e32(0, 0, 0, 1, 0));
    @(negedge clk);
    rst16 = 1'b0;
    rst32 = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      flush16   = tbl[i].flush;
      in_vec16  = tbl[i].vec;
      in_vld16  = tbl[i].vld;
      out_rdy16 = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d", i), act16(), {8'd0, tbl[i].exp});
    end

    // 32-bit MSB-first: highest index first, then async reset in the middle of a scan.
    @(negedge clk);
    in_vec32 = 32'h8000_0001; in_vld32 = 1'b1; out_rdy32 = 1'b1;
    #1 chk("m32_accept", act32(), e32(0, 0, 0, 1, 0));
    @(negedge clk);
    in_vld32 = 1'b0;
    #1 chk("m32_idx31", act32(), e32(1, 31, 0, 0, 1));
    @(negedge clk);
    #1 chk("m32_idx0", act32(), e32(1, 0, 1, 1, 1));
    @(negedge clk);
    #1 chk("m32_idle", act32(), e32(0, 0, 0, 1, 0));

    in_vld32 = 1'b1;
    @(negedge clk);
    in_vld32 = 1'b0;
    #1 chk("m32_rescan31", act32(), e32(1, 31, 0, 0, 1));
    #1 rst32 = 1'b1;
    #1 chk("m32_async_rst", act32(), e32(0, 0, 0, 1, 0));
    @(negedge clk);
    rst32 = 1'b0;
    #1 chk("m32_post_rst", act32(), e32(0, 0, 0, 1, 0));
    @(negedge clk);
    #1 chk("m32_pend_lost", act32(), e32(0, 0, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
